// File: rtl/phaser_in_tap_ctrl.sv
`timescale 1ns/1ps
// Request sequencer for the phaser input stage: turns fine-tap, counter-load and
// counter-read requests into the phaser's strobe sequences and keeps a shadow fine tap.
module phaser_in_tap_ctrl #(
    parameter int INIT_FINE     = 0,
    parameter int MAX_FINE      = 63,
    parameter int SETTLE_CYCLES = 8,
    parameter int READ_LAT      = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_OP,
    input  logic [5:0] REQ_DATA,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [5:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic       FINEENABLE,
    output logic       FINEINC,
    input  logic       FINEOVERFLOW,
    output logic       COUNTERLOADEN,
    output logic [5:0] COUNTERLOADVAL,
    output logic       COUNTERREADEN,
    input  logic [5:0] COUNTERREADVAL,
    output logic [5:0] FINE_TAP,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE, CHECK, STEP, SETTLE, LOAD, RDEN, RDWAIT, RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_FINE = 2'b00, OP_LOAD = 2'b01, OP_READ = 2'b10, OP_ILL = 2'b11
    } op_e;

    localparam logic [5:0]  INIT_TAP    = 6'(INIT_FINE);
    localparam logic [6:0]  MAX_TAP     = 7'(MAX_FINE);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] READ_LAST   = 16'(READ_LAT - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [5:0]  target_q, target_d;
    logic [5:0]  tap_q, tap_d;
    logic [5:0]  loadval_q, loadval_d;
    logic [5:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        ovf_q, ovf_d;
    logic        ovf_seen;

    assign ovf_seen = ovf_q | FINEOVERFLOW;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        op_d       = op_q;
        target_d   = target_q;
        tap_d      = tap_q;
        loadval_d  = loadval_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    op_d       = op_e'(REQ_OP);
                    target_d   = REQ_DATA;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    unique case (op_e'(REQ_OP))
                        OP_FINE: begin
                            if ({1'b0, REQ_DATA} > MAX_TAP) begin
                                state_d    = RESP;
                                rsp_err_d  = 1'b1;
                                rsp_data_d = tap_q;
                            end else begin
                                state_d = CHECK;
                            end
                        end
                        OP_LOAD: begin
                            // Latched at accept so the value is already stable during the strobe.
                            loadval_d = REQ_DATA;
                            state_d   = LOAD;
                        end
                        OP_READ: state_d = RDEN;
                        OP_ILL: begin
                            state_d   = RESP;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            CHECK: begin
                if (tap_q == target_q) begin
                    state_d    = RESP;
                    rsp_data_d = tap_q;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                dir_d   = (target_q > tap_q);
                cnt_d   = SETTLE_LAST;
                ovf_d   = 1'b0;
                state_d = SETTLE;
            end
            LOAD: begin
                cnt_d   = SETTLE_LAST;
                ovf_d   = 1'b0;
                state_d = SETTLE;
            end
            SETTLE: begin
                ovf_d = ovf_seen;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (op_q != OP_FINE) begin
                    // Overflow only concerns the fine line; a counter load settles unconditionally.
                    state_d    = RESP;
                    rsp_data_d = target_q;
                    rsp_err_d  = 1'b0;
                end else if (ovf_seen) begin
                    state_d    = RESP;
                    rsp_data_d = tap_q;
                    rsp_err_d  = 1'b1;
                end else begin
                    tap_d   = dir_q ? tap_q + 6'd1 : tap_q - 6'd1;
                    state_d = CHECK;
                end
            end
            RDEN: begin
                cnt_d   = READ_LAST;
                state_d = RDWAIT;
            end
            RDWAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d    = RESP;
                    rsp_data_d = COUNTERREADVAL;
                    rsp_err_d  = 1'b0;
                end
            end
            RESP: begin
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments; reset wins over every update.
        if (RST) begin
            state_q    <= IDLE;
            op_q       <= OP_FINE;
            target_q   <= '0;
            tap_q      <= INIT_TAP;
            loadval_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            target_q   <= target_d;
            tap_q      <= tap_d;
            loadval_q  <= loadval_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            ovf_q      <= ovf_d;
        end
    end

    // Ready is masked by RST so nothing is offered while reset is held.
    assign REQ_READY      = (state_q == IDLE) && !RST;
    assign BUSY           = (state_q != IDLE);
    assign RSP_VALID      = (state_q == RESP);
    assign RSP_DATA       = rsp_data_q;
    assign RSP_ERR        = rsp_err_q;
    assign FINEENABLE     = (state_q == STEP);
    assign FINEINC        = (state_q == STEP) && (target_q > tap_q);
    assign COUNTERLOADEN  = (state_q == LOAD);
    assign COUNTERLOADVAL = loadval_q;
    assign COUNTERREADEN  = (state_q == RDEN);
    assign FINE_TAP       = tap_q;

endmodule

// File: tb/tb_phaser_in_tap_ctrl.sv
`timescale 1ns/1ps
// Directed bench for phaser_in_tap_ctrl with a small phaser counter model.
module tb_phaser_in_tap_ctrl;

    localparam int S     = 8;
    localparam int RLAT  = 2;
    localparam int LIMIT = 200;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_OP = 2'b00;
    logic [5:0] REQ_DATA = '0;
    logic       RSP_VALID;
    logic       RSP_READY = 1'b0;
    logic [5:0] RSP_DATA;
    logic       RSP_ERR;
    logic       FINEENABLE;
    logic       FINEINC;
    logic       FINEOVERFLOW = 1'b0;
    logic       COUNTERLOADEN;
    logic [5:0] COUNTERLOADVAL;
    logic       COUNTERREADEN;
    logic [5:0] COUNTERREADVAL;
    logic [5:0] FINE_TAP;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    phaser_in_tap_ctrl #(
        .INIT_FINE(0), .MAX_FINE(62), .SETTLE_CYCLES(S), .READ_LAT(RLAT)
    ) u_dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC), .FINEOVERFLOW(FINEOVERFLOW),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
        .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL),
        .FINE_TAP(FINE_TAP), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Phaser counter model: value is valid only RLAT cycles after the read strobe.
    logic [5:0] ph_cnt = '0;
    logic [1:0] rd_pipe = '0;
    always @(posedge CLK) begin
        if (COUNTERLOADEN) ph_cnt <= COUNTERLOADVAL;
        rd_pipe <= {rd_pipe[0], COUNTERREADEN};
    end
    assign COUNTERREADVAL = rd_pipe[1] ? ph_cnt : 6'h3F;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observations of the last request, cycle numbers counted from the accept edge.
    int         n_fe;
    int         fe_cyc [8];
    logic       fe_inc [8];
    int         load_cyc, rd_cyc, rsp_cyc;
    logic [5:0] load_val, rsp_data;
    logic       rsp_err, excl_bad;

    task automatic run_req(input logic [1:0] op, input logic [5:0] data,
                           input int ovf_cyc, input int rst_cyc);
        n_fe = 0; load_cyc = 0; rd_cyc = 0; rsp_cyc = 0;
        load_val = '0; rsp_data = '0; rsp_err = 1'b0; excl_bad = 1'b0;
        @(negedge CLK);
        REQ_OP = op; REQ_DATA = data; REQ_VALID = 1'b1;
        @(posedge CLK);
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0;
            FINEOVERFLOW = (cyc == ovf_cyc);
            if (FINEENABLE && n_fe < 8) begin
                fe_cyc[n_fe] = cyc; fe_inc[n_fe] = FINEINC; n_fe++;
            end
            if (!FINEENABLE && FINEINC) excl_bad = 1'b1;
            if (int'(FINEENABLE) + int'(COUNTERLOADEN) + int'(COUNTERREADEN) > 1) excl_bad = 1'b1;
            if (COUNTERLOADEN) begin load_cyc = cyc; load_val = COUNTERLOADVAL; end
            if (COUNTERREADEN) rd_cyc = cyc;
            if (cyc == rst_cyc) begin
                FINEOVERFLOW = 1'b0; RST = 1'b1; return;
            end
            if (RSP_VALID) begin
                FINEOVERFLOW = 1'b0;
                rsp_cyc = cyc; rsp_data = RSP_DATA; rsp_err = RSP_ERR; return;
            end
        end
        FINEOVERFLOW = 1'b0;
    endtask

    task automatic take_rsp();
        RSP_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_ready_during got %b want 0", REQ_READY); end
        checks++;
        if ({RSP_VALID, RSP_ERR, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN, BUSY} !== 7'b0
            || RSP_DATA !== 6'd0 || COUNTERLOADVAL !== 6'd0 || FINE_TAP !== 6'd0) begin
            errors++;
            $display("FAIL rst_outputs got v%b e%b fe%b fi%b le%b re%b busy%b d%0d lv%0d tap%0d want all 0",
                     RSP_VALID, RSP_ERR, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN, BUSY,
                     RSP_DATA, COUNTERLOADVAL, FINE_TAP);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", REQ_READY); end
    endtask

    task automatic test_fine_same();
        run_req(2'b00, 6'd0, 0, 0);
        checks++; if (rsp_cyc !== 2) begin errors++; $display("FAIL same_rsp_cyc got %0d want 2", rsp_cyc); end
        checks++; if (rsp_data !== 6'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL same_rsp got %0d/%b want 0/0", rsp_data, rsp_err); end
        checks++; if (n_fe !== 0) begin errors++; $display("FAIL same_pulses got %0d want 0", n_fe); end
        take_rsp();
    endtask

    task automatic test_fine_up_down();
        run_req(2'b00, 6'd3, 0, 0);
        checks++; if (n_fe !== 3) begin errors++; $display("FAIL up_pulses got %0d want 3", n_fe); end
        for (int k = 0; k < 3 && k < n_fe; k++) begin
            checks++;
            if (fe_cyc[k] !== 2 + k*(S+2) || fe_inc[k] !== 1'b1) begin
                errors++; $display("FAIL up_step%0d got cyc %0d inc %b want cyc %0d inc 1", k, fe_cyc[k], fe_inc[k], 2 + k*(S+2));
            end
        end
        checks++; if (rsp_cyc !== 32) begin errors++; $display("FAIL up_rsp_cyc got %0d want 32", rsp_cyc); end
        checks++; if (rsp_data !== 6'd3 || rsp_err !== 1'b0 || FINE_TAP !== 6'd3) begin
            errors++; $display("FAIL up_rsp got %0d/%b tap %0d want 3/0 tap 3", rsp_data, rsp_err, FINE_TAP); end
        checks++; if (excl_bad !== 1'b0) begin errors++; $display("FAIL up_strobe_excl got %b want 0", excl_bad); end
        take_rsp();

        run_req(2'b00, 6'd1, 0, 0);
        checks++; if (n_fe !== 2) begin errors++; $display("FAIL down_pulses got %0d want 2", n_fe); end
        for (int k = 0; k < 2 && k < n_fe; k++) begin
            checks++;
            if (fe_cyc[k] !== 2 + k*(S+2) || fe_inc[k] !== 1'b0) begin
                errors++; $display("FAIL down_step%0d got cyc %0d inc %b want cyc %0d inc 0", k, fe_cyc[k], fe_inc[k], 2 + k*(S+2));
            end
        end
        checks++; if (rsp_cyc !== 22 || rsp_data !== 6'd1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL down_rsp got cyc %0d %0d/%b want cyc 22 1/0", rsp_cyc, rsp_data, rsp_err); end
        checks++; if (excl_bad !== 1'b0) begin errors++; $display("FAIL down_strobe_excl got %b want 0", excl_bad); end
        take_rsp();
    endtask

    task automatic test_overflow();
        run_req(2'b00, 6'd0, 0, 0);
        checks++; if (rsp_cyc !== 12 || rsp_data !== 6'd0 || n_fe !== 1) begin
            errors++; $display("FAIL ovf_prep got cyc %0d data %0d pulses %0d want 12 0 1", rsp_cyc, rsp_data, n_fe); end
        take_rsp();
        // Overflow inside the second SETTLE window (cycles 13..20): abort after it.
        run_req(2'b00, 6'd5, 15, 0);
        checks++; if (n_fe !== 2) begin errors++; $display("FAIL ovf_pulses got %0d want 2", n_fe); end
        checks++; if (rsp_cyc !== 21 || rsp_err !== 1'b1 || rsp_data !== 6'd1) begin
            errors++; $display("FAIL ovf_rsp got cyc %0d %0d/%b want cyc 21 1/1", rsp_cyc, rsp_data, rsp_err); end
        checks++; if (FINE_TAP !== 6'd1) begin errors++; $display("FAIL ovf_tap got %0d want 1", FINE_TAP); end
        take_rsp();
        // Overflow during CHECK (cycle 11) must be ignored.
        run_req(2'b00, 6'd2, 11, 0);
        checks++; if (rsp_cyc !== 12 || rsp_err !== 1'b0 || rsp_data !== 6'd2) begin
            errors++; $display("FAIL ovf_ignored got cyc %0d %0d/%b want cyc 12 2/0", rsp_cyc, rsp_data, rsp_err); end
        take_rsp();
    endtask

    task automatic test_load_read();
        run_req(2'b01, 6'h2A, 0, 0);
        checks++; if (load_cyc !== 1 || load_val !== 6'h2A) begin
            errors++; $display("FAIL load_strobe got cyc %0d val %h want cyc 1 val 2a", load_cyc, load_val); end
        checks++; if (rsp_cyc !== 2 + S || rsp_data !== 6'h2A || rsp_err !== 1'b0 || n_fe !== 0) begin
            errors++; $display("FAIL load_rsp got cyc %0d %h/%b pulses %0d want cyc %0d 2a/0 0", rsp_cyc, rsp_data, rsp_err, n_fe, 2 + S); end
        take_rsp();
        checks++; if (COUNTERLOADVAL !== 6'h2A) begin errors++; $display("FAIL load_hold got %h want 2a", COUNTERLOADVAL); end

        run_req(2'b10, 6'd0, 0, 0);
        checks++; if (rd_cyc !== 1) begin errors++; $display("FAIL read_strobe got cyc %0d want 1", rd_cyc); end
        checks++; if (rsp_cyc !== 2 + RLAT || rsp_data !== 6'h2A || rsp_err !== 1'b0) begin
            errors++; $display("FAIL read_rsp got cyc %0d %h/%b want cyc %0d 2a/0", rsp_cyc, rsp_data, rsp_err, 2 + RLAT); end
        checks++; if (FINE_TAP !== 6'd2 || excl_bad !== 1'b0) begin
            errors++; $display("FAIL read_side got tap %0d excl %b want 2 0", FINE_TAP, excl_bad); end
        take_rsp();
    endtask

    task automatic test_errors_hold();
        run_req(2'b11, 6'h15, 0, 0);
        checks++; if (rsp_cyc !== 1 || rsp_err !== 1'b1 || rsp_data !== 6'd0) begin
            errors++; $display("FAIL ill_rsp got cyc %0d %0d/%b want cyc 1 0/1", rsp_cyc, rsp_data, rsp_err); end
        checks++; if (n_fe !== 0 || load_cyc !== 0 || rd_cyc !== 0) begin
            errors++; $display("FAIL ill_strobes got fe %0d ld %0d rd %0d want 0 0 0", n_fe, load_cyc, rd_cyc); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (RSP_VALID !== 1'b1 || RSP_DATA !== 6'd0 || RSP_ERR !== 1'b1 || REQ_READY !== 1'b0) begin
                errors++; $display("FAIL hold%0d got v%b d%0d e%b rdy%b want v1 d0 e1 rdy0", i, RSP_VALID, RSP_DATA, RSP_ERR, REQ_READY);
            end
        end
        take_rsp();
        checks++; if (REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL hold_release got rdy %b busy %b want 1 0", REQ_READY, BUSY); end

        // Target just above MAX_FINE (62) is rejected without phaser activity.
        run_req(2'b00, 6'd63, 0, 0);
        checks++; if (rsp_cyc !== 1 || rsp_err !== 1'b1 || rsp_data !== 6'd2 || n_fe !== 0) begin
            errors++; $display("FAIL range_rsp got cyc %0d %0d/%b pulses %0d want cyc 1 2/1 0", rsp_cyc, rsp_data, rsp_err, n_fe); end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        logic stray;
        run_req(2'b00, 6'd5, 0, 15);
        @(negedge CLK);
        checks++;
        if ({RSP_VALID, RSP_ERR, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN, BUSY, REQ_READY} !== 8'b0
            || RSP_DATA !== 6'd0 || COUNTERLOADVAL !== 6'd0 || FINE_TAP !== 6'd0) begin
            errors++;
            $display("FAIL midrst_outputs got v%b e%b fe%b fi%b le%b re%b busy%b rdy%b d%0d lv%h tap%0d want all 0",
                     RSP_VALID, RSP_ERR, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN, BUSY, REQ_READY,
                     RSP_DATA, COUNTERLOADVAL, FINE_TAP);
        end
        RST = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (RSP_VALID || FINEENABLE || BUSY || !REQ_READY) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL midrst_quiet got %b want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_fine_same();
        test_fine_up_down();
        test_overflow();
        test_load_read();
        test_errors_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
